// File: rtl/seq_det_pkg.sv
// Shared definitions for the "101" non-overlapping serial pattern detector:
// the state encoding, the pattern constant and the default match-counter width.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GOT1    = 2'b01,
    GOT10   = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  // Bit 2 is the first bit received on the line.
  localparam logic [2:0] PATTERN = 3'b101;

  localparam int CNT_W_DEF = 8;

endpackage : seq_det_pkg

// File: rtl/seq_det_non_overlap.sv
// Non-overlapping "101" detector, MSB first, with a registered one-cycle match pulse.
// Define SEQ_DET_CNT_EN to add the saturating det_count output and its CNT_W parameter.
module seq_det_non_overlap
  import seq_det_pkg::*;
`ifdef SEQ_DET_CNT_EN
#(
  parameter int CNT_W = CNT_W_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq_in,
  output logic             detected,
  output logic [1:0]       state_out
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] det_count
`endif
);

  state_e state_q, state_d;
  logic   detected_q, detected_d;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    detected_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (seq_in == PATTERN[2]) state_d = GOT1;
      end
      GOT1: begin
        // A repeated '1' simply becomes the new start of the pattern.
        if (seq_in == PATTERN[1]) state_d = GOT10;
      end
      GOT10: begin
        // Both outcomes return to IDLE; on a match no bit is carried into the next search.
        state_d    = IDLE;
        detected_d = (seq_in == PATTERN[0]);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      detected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      detected_q <= detected_d;
    end
  end

  assign detected  = detected_q;
  assign state_out = state_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;

  always_comb begin
    det_cnt_d = det_cnt_q;
    if (detected_d && (det_cnt_q != {CNT_W{1'b1}})) det_cnt_d = det_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) det_cnt_q <= '0;
    else        det_cnt_q <= det_cnt_d;
  end

  assign det_count = det_cnt_q;
`endif

endmodule : seq_det_non_overlap

// File: tb/tb_seq_det_non_overlap.sv
// Directed, table-driven bench for seq_det_non_overlap; also checks det_count when
// built with SEQ_DET_CNT_EN.
module tb_seq_det_non_overlap;
  import seq_det_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       seq_in;
  logic       detected;
  logic [1:0] state_out;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] det_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  seq_det_non_overlap dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq_in    (seq_in),
    .detected  (detected),
    .state_out (state_out)
`ifdef SEQ_DET_CNT_EN
    ,
    .det_count (det_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       in;
    logic       det;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one bit, let one posedge sample it, then check both outputs just after the edge.
  task automatic step(input logic b, input logic exp_det, input logic [1:0] exp_st,
                      input string name);
    seq_in = b;
    @(posedge clk);
    #1;
    check({name, ".detected"}, {7'd0, detected}, {7'd0, exp_det});
    check({name, ".state_out"}, {6'd0, state_out}, {6'd0, exp_st});
    if (exp_det) exp_cnt++;
  endtask

  // Reference model for random stimulus: a match is the last three bits equal to
  // PATTERN with at least three bits received since the previous match or reset.
  logic [2:0] m_hist;
  int         m_since;

  task automatic model_bit(input logic b, output logic exp_det);
    m_hist  = {m_hist[1:0], b};
    m_since = m_since + 1;
    exp_det = (m_hist == PATTERN) && (m_since >= 3);
    if (exp_det) m_since = 0;
  endtask

  initial begin
    logic [14:0] rnd_bits;
    logic        exp_det;
    logic        prev_det;

    // "00_1100_0101_0101", MSB first, with the hand-derived state trace.
    vecs[0]  = '{1'b0, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 1'b0, 2'b00};
    vecs[2]  = '{1'b1, 1'b0, 2'b01};
    vecs[3]  = '{1'b1, 1'b0, 2'b01};
    vecs[4]  = '{1'b0, 1'b0, 2'b10};
    vecs[5]  = '{1'b0, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 1'b0, 2'b00};
    vecs[7]  = '{1'b1, 1'b0, 2'b01};
    vecs[8]  = '{1'b0, 1'b0, 2'b10};
    vecs[9]  = '{1'b1, 1'b1, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 2'b00};
    vecs[11] = '{1'b1, 1'b0, 2'b01};
    vecs[12] = '{1'b0, 1'b0, 2'b10};
    vecs[13] = '{1'b1, 1'b1, 2'b00};

    // Reset held from t=0 to 2.5us; seq_in toggling must have no effect.
    rst_n  = 1'b0;
    seq_in = 1'b0;
    #100;
    check("rst_early.detected", {7'd0, detected}, 8'd0);
    check("rst_early.state_out", {6'd0, state_out}, 8'd0);
    seq_in = 1'b1;
    #900;
    check("rst_mid.detected", {7'd0, detected}, 8'd0);
    check("rst_mid.state_out", {6'd0, state_out}, 8'd0);
    #1400;
    check("rst_late.state_out", {6'd0, state_out}, 8'd0);
`ifdef SEQ_DET_CNT_EN
    check("rst.det_count", det_count, 8'd0);
`endif
    seq_in = 1'b0;
    #100;
    rst_n = 1'b1;

    step(1'b0, 1'b0, 2'b00, "idle0");
    step(1'b0, 1'b0, 2'b00, "idle1");

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].in, vecs[i].det, vecs[i].st, $sformatf("vec[%0d]", i));
    end
`ifdef SEQ_DET_CNT_EN
    check("vec.det_count", det_count, 8'(exp_cnt));
`endif

    // Non-overlap: 10101 matches once; the trailing 1 is only a new start.
    step(1'b1, 1'b0, 2'b01, "novl.b1");
    step(1'b0, 1'b0, 2'b10, "novl.b2");
    step(1'b1, 1'b1, 2'b00, "novl.b3");
    step(1'b0, 1'b0, 2'b00, "novl.b4");
    step(1'b1, 1'b0, 2'b01, "novl.b5");
    step(1'b0, 1'b0, 2'b10, "flush.a");
    step(1'b0, 1'b0, 2'b00, "flush.b");

    // Repeated ones keep the detector in GOT1.
    step(1'b1, 1'b0, 2'b01, "ones.b1");
    step(1'b1, 1'b0, 2'b01, "ones.b2");
    step(1'b1, 1'b0, 2'b01, "ones.b3");
    step(1'b0, 1'b0, 2'b10, "ones.b4");
    step(1'b1, 1'b1, 2'b00, "ones.b5");

    // Reset mid-pattern discards the partial "10".
    step(1'b1, 1'b0, 2'b01, "rmid.b1");
    step(1'b0, 1'b0, 2'b10, "rmid.b2");
    seq_in = 1'b1;
    rst_n  = 1'b0;
    exp_cnt = 0;
    #1;
    check("rmid.async_state", {6'd0, state_out}, 8'd0);
    @(posedge clk);
    #1;
    check("rmid.held_detected", {7'd0, detected}, 8'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2'b01, "rmid.after");

    // Reset while the pulse is high must drop it without waiting for an edge.
    step(1'b0, 1'b0, 2'b10, "rdrop.b0");
    step(1'b1, 1'b1, 2'b00, "rdrop.b1");
    rst_n  = 1'b0;
    seq_in = 1'b0;
    exp_cnt = 0;
    #1;
    check("rdrop.detected", {7'd0, detected}, 8'd0);
`ifdef SEQ_DET_CNT_EN
    check("rdrop.det_count", det_count, 8'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random stream against the reference model, starting from IDLE.
    m_hist   = 3'b000;
    m_since  = 0;
    prev_det = 1'b0;
    rnd_bits = 15'($urandom);
    for (int i = 0; i < 15; i++) begin
      model_bit(rnd_bits[14-i], exp_det);
      seq_in = rnd_bits[14-i];
      @(posedge clk);
      #1;
      check($sformatf("rnd[%0d].detected", i), {7'd0, detected}, {7'd0, exp_det});
      check($sformatf("rnd[%0d].no_double", i), {7'd0, detected & prev_det}, 8'd0);
      prev_det = detected;
      if (exp_det) exp_cnt++;
    end
`ifdef SEQ_DET_CNT_EN
    check("rnd.det_count", det_count, 8'(exp_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seq_det_non_overlap
